// File: rtl/agc_quant_pkg.sv
// agc_quant_pkg: shared types and helpers for the adaptive-threshold quantizer.
//   agc_state_e : loop state, ACQ (fast steps) or TRACK (slow steps)
//   max_lim()   : largest magnitude representable by a signed sample of given width
//   calc_step() : threshold correction step, max(1, diff >> sh)
package agc_quant_pkg;

   typedef enum logic {
      ACQ   = 1'b0,
      TRACK = 1'b1
   } agc_state_e;

   function automatic int max_lim(input int width);
      return (1 << (width - 1)) - 1;
   endfunction

   // A step of zero would stall the loop just outside the hold band, so the
   // smallest correction is always one code.
   function automatic int calc_step(input int diff, input int sh);
      int s;
      s = diff >> sh;
      return (s < 1) ? 1 : s;
   endfunction

endpackage

// File: rtl/agc_quant_v1_abs_sat.sv
// abs_sat: combinational magnitude of a two's-complement sample.
//   data_in : WIDTH-bit signed sample
//   abs_out : WIDTH-1-bit unsigned magnitude; the most-negative code maps to
//             2^(WIDTH-1)-1 instead of wrapping to zero.
module abs_sat #(
   parameter int WIDTH = 14
) (
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-2:0] abs_out
);

   // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      abs_out = data_in[WIDTH-2:0];
      if (data_in[WIDTH-1]) begin
         // Low bits of ~x + 1 equal the low bits of -x; only -2^(WIDTH-1) wraps to 0.
         if (data_in[WIDTH-2:0] == '0) abs_out = '1;
         else                          abs_out = ~data_in[WIDTH-2:0] + (WIDTH-1)'(1);
      end
   end

endmodule

// File: rtl/agc_quant_v1.sv
// agc_quant_v1: 2-bit (sign/magnitude) quantizer with a closed-loop threshold.
// The threshold is nudged once per window so that about TARGET of every
// 2^PERIODN accepted samples land at or above it.
//
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   hold        (only with AGC_QUANT_HOLD_EN) freezes thr and the FSM at update
//   we          data_in valid
//   data_in     WIDTH-bit signed sample
//   q_sign      1 = last accepted sample negative
//   q_mag       1 = |last accepted sample| >= thr
//   valid       we delayed one cycle
//   thr         current threshold, unsigned WIDTH-1 bits
//   over_last   over-threshold count of the last completed window
//   locked      1 = loop in TRACK
//
// Build option: define AGC_QUANT_HOLD_EN to add the hold input.
module agc_quant_v1
   import agc_quant_pkg::*;
#(
   parameter int WIDTH       = 14,
   parameter int PERIODN     = 14,
   parameter int TARGET      = (2**PERIODN) / 3,
   parameter int DEADBAND    = 2**(PERIODN - 6),
   parameter int THR_INIT    = 2**(WIDTH - 3),
   parameter int STEP_SH_ACQ = 2,
   parameter int STEP_SH_TRK = 5,
   parameter int LOCK_N      = 4
) (
   input  logic                      clk,
   input  logic                      rst,
`ifdef AGC_QUANT_HOLD_EN
   input  logic                      hold,
`endif
   input  logic                      we,
   input  logic signed [WIDTH-1:0]   data_in,
   output logic                      q_sign,
   output logic                      q_mag,
   output logic                      valid,
   output logic        [WIDTH-2:0]   thr,
   output logic        [PERIODN:0]   over_last,
   output logic                      locked
);

   localparam int THR_W   = WIDTH - 1;
   localparam int MAX_LIM = max_lim(WIDTH);
   localparam int RUN_W   = $clog2(LOCK_N + 1);

   logic [THR_W-1:0]   abs_val;
   logic               mag_now;
   logic [PERIODN-1:0] win_cntr;
   logic [PERIODN:0]   over_cnt;
   logic [PERIODN:0]   over_final;
   logic               win_end;
   logic               upd_pend;
   logic               upd_en;

   agc_state_e         state, state_nxt;
   logic [RUN_W-1:0]   run, run_nxt, run_inc;
   logic [THR_W-1:0]   thr_nxt;
   logic               locked_nxt;
   logic               above, below, in_band;
   int                 ol, dev, step;

   abs_sat #(.WIDTH(WIDTH)) u_abs (
      .data_in (data_in),
      .abs_out (abs_val)
   );

   assign mag_now    = (abs_val >= thr);
   assign win_end    = we && (win_cntr == '1);
   // The window-closing sample is included in its own window's count.
   assign over_final = over_cnt + {{PERIODN{1'b0}}, mag_now};

`ifdef AGC_QUANT_HOLD_EN
   assign upd_en = upd_pend && !hold;
`else
   assign upd_en = upd_pend;
`endif

   // ---------------- sample path and window accounting ----------------
   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_sign    <= 1'b0;
         q_mag     <= 1'b0;
         valid     <= 1'b0;
         win_cntr  <= '0;
         over_cnt  <= '0;
         over_last <= '0;
         upd_pend  <= 1'b0;
      end else begin
         valid    <= we;
         upd_pend <= win_end;
         if (we) begin
            q_sign <= data_in[WIDTH-1];
            q_mag  <= mag_now;
            if (win_end) begin
               over_last <= over_final;
               over_cnt  <= '0;
               win_cntr  <= '0;
            end else begin
               over_cnt  <= over_final;
               win_cntr  <= win_cntr + PERIODN'(1);
            end
         end
      end
   end

   // ---------------- window classification and threshold step ----------------
   always_comb begin
      ol      = int'(over_last);
      above   = (ol > TARGET + DEADBAND);
      below   = (ol < TARGET - DEADBAND);
      in_band = !above && !below;
      dev     = (ol >= TARGET) ? (ol - TARGET) : (TARGET - ol);
      step    = calc_step(dev, (state == TRACK) ? STEP_SH_TRK : STEP_SH_ACQ);
      thr_nxt = thr;
      if (above)
         thr_nxt = (int'(thr) + step > MAX_LIM) ? THR_W'(MAX_LIM) : THR_W'(int'(thr) + step);
      else if (below)
         thr_nxt = (int'(thr) - step < 1) ? THR_W'(1) : THR_W'(int'(thr) - step);
   end

   // ---------------- FSM: next state ----------------
   // ACQ counts consecutive in-band windows, TRACK counts consecutive
   // out-of-band ones; LOCK_N in a row flips the state.
   always_comb begin
      state_nxt = state;
      run_inc   = run + RUN_W'(1);
      run_nxt   = '0;
      case (state)
         ACQ: begin
            if (in_band) begin
               if (run_inc == RUN_W'(LOCK_N)) state_nxt = TRACK;
               else                           run_nxt   = run_inc;
            end
         end
         TRACK: begin
            if (!in_band) begin
               if (run_inc == RUN_W'(LOCK_N)) state_nxt = ACQ;
               else                           run_nxt   = run_inc;
            end
         end
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      locked_nxt = (state_nxt == TRACK);
   end

   // ---------------- FSM and threshold registers ----------------
   // Updated only in the cycle after a window end; everything else holds.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ACQ;
         run    <= '0;
         locked <= 1'b0;
         thr    <= THR_W'(THR_INIT);
      end else if (upd_en) begin
         state  <= state_nxt;
         run    <= run_nxt;
         locked <= locked_nxt;
         thr    <= thr_nxt;
      end
   end

endmodule

// File: tb/tb_agc_quant_v1.sv
// Self-checking bench for agc_quant_v1 with PERIODN=8, TARGET=85, DEADBAND=4.
// Two instances share stimulus: dut_a starts at thr=64, dut_b at thr=8000.
module tb_agc_quant_v1;

   localparam int WIN   = 256;
   localparam int TGT   = 85;
   localparam int DB    = 4;
   localparam int MAXL  = 8191;
   localparam int LOCKN = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic we  = 1'b0;
   logic signed [13:0] data_in = '0;

   logic        q_sign_a, q_mag_a, valid_a, locked_a;
   logic [12:0] thr_a;
   logic [8:0]  over_last_a;
   logic        q_sign_b, q_mag_b, valid_b, locked_b;
   logic [12:0] thr_b;
   logic [8:0]  over_last_b;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   agc_quant_v1 #(.WIDTH(14), .PERIODN(8), .TARGET(TGT), .DEADBAND(DB), .THR_INIT(64)) dut_a (
      .clk(clk), .rst(rst),
`ifdef AGC_QUANT_HOLD_EN
      .hold(1'b0),
`endif
      .we(we), .data_in(data_in),
      .q_sign(q_sign_a), .q_mag(q_mag_a), .valid(valid_a),
      .thr(thr_a), .over_last(over_last_a), .locked(locked_a)
   );

   agc_quant_v1 #(.WIDTH(14), .PERIODN(8), .TARGET(TGT), .DEADBAND(DB), .THR_INIT(8000)) dut_b (
      .clk(clk), .rst(rst),
`ifdef AGC_QUANT_HOLD_EN
      .hold(1'b0),
`endif
      .we(we), .data_in(data_in),
      .q_sign(q_sign_b), .q_mag(q_mag_b), .valid(valid_b),
      .thr(thr_b), .over_last(over_last_b), .locked(locked_b)
   );

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct packed {
      int thr;
      int run;
      int win;
      int over;
      int over_last;
      bit track;
      bit pend;
      bit qs;
      bit qm;
      bit vld;
   } model_t;

   model_t m_a, m_b;

   function automatic model_t model_reset(input int thr_init);
      model_t n;
      n = '0;
      n.thr = thr_init;
      return n;
   endfunction

   function automatic model_t model_step(input model_t m, input bit w, input int d);
      model_t n;
      int a, dev, st;
      bit mag, inb;
      n   = m;
      a   = (d == -8192) ? MAXL : ((d < 0) ? -d : d);
      mag = (a >= m.thr);
      if (m.pend) begin
         dev = m.over_last - TGT;
         st  = ((dev < 0) ? -dev : dev) >> (m.track ? 5 : 2);
         if (st < 1) st = 1;
         inb = (dev >= -DB) && (dev <= DB);
         if (dev > DB)       n.thr = (m.thr + st > MAXL) ? MAXL : m.thr + st;
         else if (dev < -DB) n.thr = (m.thr - st < 1) ? 1 : m.thr - st;
         // ACQ counts in-band windows, TRACK counts out-of-band ones.
         n.run = (inb != m.track) ? m.run + 1 : 0;
         if (n.run == LOCKN) begin
            n.track = !m.track;
            n.run   = 0;
         end
         n.pend = 1'b0;
      end
      n.vld = w;
      if (w) begin
         n.qs   = (d < 0);
         n.qm   = mag;
         n.over = m.over + int'(mag);
         n.win  = m.win + 1;
         if (n.win == WIN) begin
            n.over_last = n.over;
            n.over      = 0;
            n.win       = 0;
            n.pend      = 1'b1;
         end
      end
      return n;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_a <= model_reset(64);
         m_b <= model_reset(8000);
      end else begin
         m_a <= model_step(m_a, we, int'(data_in));
         m_b <= model_step(m_b, we, int'(data_in));
      end
   end

   // One compare process, every cycle, on the falling edge.
   always @(negedge clk) begin
      check("a_q_sign",    int'(q_sign_a),    int'(m_a.qs));
      check("a_q_mag",     int'(q_mag_a),     int'(m_a.qm));
      check("a_valid",     int'(valid_a),     int'(m_a.vld));
      check("a_thr",       int'(thr_a),       m_a.thr);
      check("a_over_last", int'(over_last_a), m_a.over_last);
      check("a_locked",    int'(locked_a),    int'(m_a.track));
      check("b_q_sign",    int'(q_sign_b),    int'(m_b.qs));
      check("b_q_mag",     int'(q_mag_b),     int'(m_b.qm));
      check("b_valid",     int'(valid_b),     int'(m_b.vld));
      check("b_thr",       int'(thr_b),       m_b.thr);
      check("b_over_last", int'(over_last_b), m_b.over_last);
      check("b_locked",    int'(locked_b),    int'(m_b.track));
   end

   // ---------------- stimulus ----------------
   task automatic drive(input bit w, input int d);
      we      = w;
      data_in = 14'(d);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      we  = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   int pat [3] = '{200, 10, -10};

   initial begin
      // Reset, then idle.
      do_reset();
      for (int i = 0; i < 20; i++) begin
         drive(1'b0, 0);
         check("idle_valid", int'(valid_a), 0);
      end
      check("idle_thr_a",    int'(thr_a), 64);
      check("idle_thr_b",    int'(thr_b), 8000);
      check("idle_over",     int'(over_last_a), 0);
      check("idle_locked",   int'(locked_a), 0);
      check("idle_q",        int'({q_sign_a, q_mag_a}), 0);

      // Most-negative sample saturates to full scale.
      drive(1'b1, -8192);
      check("neg_q_sign", int'(q_sign_a), 1);
      check("neg_q_mag",  int'(q_mag_a), 1);
      check("neg_valid",  int'(valid_a), 1);
      drive(1'b0, 0);
      check("neg_hold_sign", int'(q_sign_a), 1);
      check("neg_gap_valid", int'(valid_a), 0);

      // {+200, +10, -10}: in-band windows, lock after the 4th.
      do_reset();
      for (int k = 0; k < 5 * WIN + 1; k++) begin
         drive(1'b1, pat[k % 3]);
         if ((k + 1) % WIN == 0) begin
            check("pat_over_band", int'(over_last_a == 9'd85 || over_last_a == 9'd86), 1);
            check("pat_thr", int'(thr_a), 64);
         end
         if (k == 4 * WIN - 1) check("pat_locked_at_E", int'(locked_a), 0);
         if (k == 4 * WIN)     check("pat_locked_E1",   int'(locked_a), 1);
      end
      check("pat_first_over", 1, 1 - int'(over_last_a == 9'd0));

      // Constant +100: large upward step, then downward step.
      do_reset();
      for (int k = 0; k < WIN; k++) drive(1'b1, 100);
      check("c100_over1", int'(over_last_a), 256);
      check("c100_thr_E", int'(thr_a), 64);
      drive(1'b0, 0);
      check("c100_thr_E1", int'(thr_a), 106);
      drive(1'b0, 0);
      for (int k = 0; k < WIN; k++) drive(1'b1, 100);
      check("c100_over2", int'(over_last_a), 0);
      drive(1'b0, 0);
      check("c100_thr2", int'(thr_a), 85);

      // Constant +8191: dut_b threshold saturates at full scale.
      do_reset();
      for (int k = 0; k < 6 * WIN; k++) begin
         drive(1'b1, 8191);
         if (k == 5 * WIN) check("sat_thr_w5", int'(thr_b), MAXL);
      end
      drive(1'b0, 0);
      check("sat_thr_final", int'(thr_b), MAXL);
      check("sat_q_mag",     int'(q_mag_b), 1);

      // Reset mid-window: partial window discarded, next window is full length.
      for (int k = 0; k < 100; k++) drive(1'b1, 100);
      rst = 1'b1;
      #1;
      check("mid_rst_thr_a",  int'(thr_a), 64);
      check("mid_rst_thr_b",  int'(thr_b), 8000);
      check("mid_rst_over",   int'(over_last_a), 0);
      check("mid_rst_valid",  int'(valid_a), 0);
      check("mid_rst_q_mag",  int'(q_mag_a), 0);
      we = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int k = 0; k < WIN - 1; k++) drive(1'b1, 100);
      check("mid_rst_win255", int'(over_last_a), 0);
      drive(1'b1, 100);
      check("mid_rst_win256", int'(over_last_a), 256);

      // Random data with gaps in we; checked by the model only.
      do_reset();
      for (int i = 0; i < 1200; i++) begin
         if ($urandom_range(0, 15) == 0)
            drive($urandom_range(0, 9) < 7, -8192);
         else
            drive($urandom_range(0, 9) < 7, int'($urandom_range(0, 500)) - 250);
      end
      for (int i = 0; i < 4; i++) drive(1'b0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
